// File: rtl/tdc_capture_controller.sv
// Single-measurement TDC sequencer: arms a coarse counter, captures the tap snapshot on a tap-0
// rising edge, popcount-encodes it a chunk per cycle and hands {coarse, fine} downstream.
module tdc_capture_controller #(
    parameter int MAX_LENGTH = 2048,
    parameter int CHUNK      = 256,
    parameter int COARSE_W   = 16,
    parameter int FINE_W     = $clog2(4*MAX_LENGTH+1)
) (
    input  logic                    clk_input,
    input  logic                    rst_input,
    input  logic [31:0]             cfg_length,
    input  logic                    arm,
    input  logic                    continuous,
    input  logic [4*MAX_LENGTH-1:0] tap_in,
    output logic [31:0]             line_length,
    output logic                    busy,
    output logic                    ts_valid,
    input  logic                    ts_ready,
    output logic [COARSE_W-1:0]     ts_coarse,
    output logic [FINE_W-1:0]       ts_fine,
    output logic                    ts_timeout,
    output logic                    ts_sat,
    output logic [15:0]             missed_cnt
);
    localparam int TAPS   = 4*MAX_LENGTH;
    localparam int NCHUNK = TAPS/CHUNK;
    localparam int IDX_W  = $clog2(NCHUNK+1);

    typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_ENCODE, ST_OUTPUT} state_t;
    state_t state_q, state_d;

    logic                tap0_p0;
    logic [COARSE_W-1:0] coarse_p0;
    logic [TAPS-1:0]     snap_p1;
    logic [COARSE_W-1:0] coarse_cap_p1;
    logic [FINE_W-1:0]   acc_p1;
    logic [IDX_W-1:0]    idx_p1;

    logic                hit, capture, timeout, enc_last, accept, start_coarse, count_miss;
    logic [31:0]         len_clamped, taps_active, k_last;
    logic [TAPS-1:0]     tap_mask;
    logic [CHUNK-1:0]    chunk_bits;
    logic [FINE_W-1:0]   acc_next;
    logic                fine_full;

    function automatic logic [FINE_W-1:0] popcount(input logic [CHUNK-1:0] v);
        logic [FINE_W-1:0] n;
        n = '0;
        for (int i = 0; i < CHUNK; i++) n = n + FINE_W'(v[i]);
        return n;
    endfunction

    function automatic logic [31:0] clamp_length(input logic [31:0] req);
        if (req == 32'd0)                 return 32'd1;
        else if (req > 32'(MAX_LENGTH))   return 32'(MAX_LENGTH);
        else                              return req;
    endfunction

    assign hit         = tap_in[0] & ~tap0_p0;
    assign len_clamped = clamp_length(cfg_length);
    assign taps_active = line_length << 2;
    // Shifting by the full width yields zero, so a full-length line keeps every tap.
    assign tap_mask    = ~({TAPS{1'b1}} << taps_active);
    assign k_last      = (taps_active + 32'(CHUNK) - 32'd1) / 32'(CHUNK) - 32'd1;
    assign chunk_bits  = snap_p1[int'(idx_p1)*CHUNK +: CHUNK];
    assign acc_next    = acc_p1 + popcount(chunk_bits);
    assign fine_full   = (32'(acc_next) == taps_active);
    assign busy        = (state_q != ST_IDLE);
    assign count_miss  = hit && (state_q == ST_ENCODE || state_q == ST_OUTPUT);
    assign start_coarse = ((state_q == ST_IDLE) && arm) || (accept && continuous);

    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        timeout  = 1'b0;
        enc_last = 1'b0;
        accept   = 1'b0;
        case (state_q)
            ST_IDLE:   if (arm) state_d = ST_ARMED;
            ST_ARMED: begin
                if (hit) begin
                    capture = 1'b1;
                    state_d = ST_ENCODE;
                end else if (&coarse_p0) begin
                    timeout = 1'b1;
                    state_d = ST_OUTPUT;
                end
            end
            ST_ENCODE: begin
                if (32'(idx_p1) == k_last) begin
                    enc_last = 1'b1;
                    state_d  = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                if (ts_valid && ts_ready) begin
                    accept  = 1'b1;
                    state_d = continuous ? ST_ARMED : ST_IDLE;
                end
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_input) begin
        if (rst_input) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    // Control and output stage
    always_ff @(posedge clk_input) begin
        if (rst_input) begin
            tap0_p0     <= 1'b0;
            line_length <= 32'd1;
            ts_valid    <= 1'b0;
            ts_timeout  <= 1'b0;
            ts_sat      <= 1'b0;
            ts_coarse   <= '0;
            ts_fine     <= '0;
            missed_cnt  <= 16'd0;
        end else begin
            tap0_p0 <= tap_in[0];
            if (state_q == ST_IDLE) line_length <= len_clamped;
            if (count_miss && missed_cnt != 16'hFFFF) missed_cnt <= missed_cnt + 16'd1;
            if (timeout) begin
                ts_valid   <= 1'b1;
                ts_timeout <= 1'b1;
                ts_sat     <= 1'b0;
                ts_coarse  <= '1;
                ts_fine    <= '0;
            end else if (enc_last) begin
                ts_valid  <= 1'b1;
                ts_fine   <= acc_next;
                ts_coarse <= coarse_cap_p1;
                ts_sat    <= fine_full;
            end else if (accept) begin
                ts_valid   <= 1'b0;
                ts_timeout <= 1'b0;
                ts_sat     <= 1'b0;
            end
        end
    end

    // Capture (p0) and encode (p1) datapath
    always_ff @(posedge clk_input) begin
        if (start_coarse)               coarse_p0 <= '0;
        else if (state_q == ST_ARMED)   coarse_p0 <= coarse_p0 + COARSE_W'(1);
        if (capture) begin
            snap_p1       <= tap_in & tap_mask;
            coarse_cap_p1 <= coarse_p0;
            acc_p1        <= '0;
            idx_p1        <= '0;
        end else if (state_q == ST_ENCODE) begin
            acc_p1 <= acc_next;
            idx_p1 <= idx_p1 + IDX_W'(1);
        end
    end
endmodule
